// File: rtl/rtype_seq_ctrl_pkg.sv
// Shared constants for the R-type sequencer: state encoding, opcode/func
// field values and the 4-bit ALU opcode map.
package rtype_seq_ctrl_pkg;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE   = 3'd0;
    localparam state_t ST_FETCH  = 3'd1;
    localparam state_t ST_DECODE = 3'd2;
    localparam state_t ST_EXEC   = 3'd3;
    localparam state_t ST_WB     = 3'd4;
    localparam state_t ST_HALT   = 3'd5;

    localparam logic [5:0] OP_RTYPE = 6'b000000;

    localparam logic [5:0] FN_ADD  = 6'b100000;
    localparam logic [5:0] FN_SUB  = 6'b100010;
    localparam logic [5:0] FN_AND  = 6'b100100;
    localparam logic [5:0] FN_OR   = 6'b100101;
    localparam logic [5:0] FN_XOR  = 6'b100110;
    localparam logic [5:0] FN_NOR  = 6'b100111;
    localparam logic [5:0] FN_SLTU = 6'b101011;
    localparam logic [5:0] FN_SLLV = 6'b000100;

    localparam logic [3:0] ALU_AND  = 4'b0000;
    localparam logic [3:0] ALU_OR   = 4'b0001;
    localparam logic [3:0] ALU_XOR  = 4'b0010;
    localparam logic [3:0] ALU_NOR  = 4'b0011;
    localparam logic [3:0] ALU_ADD  = 4'b0100;
    localparam logic [3:0] ALU_SUB  = 4'b0101;
    localparam logic [3:0] ALU_SLTU = 4'b0110;
    localparam logic [3:0] ALU_SLLV = 4'b0111;

endpackage

// File: rtl/rtype_seq_ctrl_if.sv
// Instruction-memory fetch handshake between the sequencer (master) and
// instruction memory (slave).
interface rtype_seq_ctrl_if;

    logic        imem_req;
    logic        imem_ack;
    logic [31:0] instr;

    modport master (
        output imem_req,
        input  imem_ack,
        input  instr
    );

    modport slave (
        input  imem_req,
        output imem_ack,
        output instr
    );

endinterface

// File: rtl/rtype_alu_dec.sv
// Combinational R-type decoder: (op, func) -> ALU opcode, register-write
// flag and legality. func=0 with OP=0 is a legal NOP that writes nothing.
module rtype_alu_dec
    import rtype_seq_ctrl_pkg::*;
(
    input  logic [5:0] op,
    input  logic [5:0] func,
    output logic [3:0] alu_op,
    output logic       wr,
    output logic       legal
);

    logic hit;

    // Table lookup; anything outside the table keeps ALU_AND (0000).
    always_comb begin
        alu_op = ALU_AND;
        hit    = 1'b0;
        if (op == OP_RTYPE) begin
            unique case (func)
                FN_ADD:  begin alu_op = ALU_ADD;  hit = 1'b1; end
                FN_SUB:  begin alu_op = ALU_SUB;  hit = 1'b1; end
                FN_AND:  begin alu_op = ALU_AND;  hit = 1'b1; end
                FN_OR:   begin alu_op = ALU_OR;   hit = 1'b1; end
                FN_XOR:  begin alu_op = ALU_XOR;  hit = 1'b1; end
                FN_NOR:  begin alu_op = ALU_NOR;  hit = 1'b1; end
                FN_SLTU: begin alu_op = ALU_SLTU; hit = 1'b1; end
                FN_SLLV: begin alu_op = ALU_SLLV; hit = 1'b1; end
                default: begin alu_op = ALU_AND;  hit = 1'b0; end
            endcase
        end
    end

    assign wr    = hit && (func != 6'd0);
    assign legal = (op == OP_RTYPE) && (hit || (func == 6'd0));

endmodule

// File: rtl/rtype_seq_ctrl.sv
// Multi-cycle FETCH/DECODE/EXEC/WB sequencer for the R-type datapath.
// Sole source of datapath write enables; counts retired instructions.
// Optional macro RTYPE_ILLEGAL_TRAP_EN: illegal instructions set the sticky
// illegal flag, write nothing, are not counted and halt the sequencer.
module rtype_seq_ctrl
    import rtype_seq_ctrl_pkg::*;
#(
    parameter int unsigned CNT_W    = 16,
    parameter int unsigned FETCH_TO = 15
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             run,
    rtype_seq_ctrl_if.master imem,
    output logic             ir_we,
    output logic             pc_we,
    output logic             ab_we,
    output logic             alu_res_we,
    output logic             rf_we,
    output logic [4:0]       rf_waddr,
    output logic [3:0]       alu_op,
    output logic             busy,
    output logic             fetch_err,
    output logic             illegal,
    output logic [CNT_W-1:0] retired_cnt
);

    localparam int unsigned     TO_W    = (FETCH_TO > 1) ? $clog2(FETCH_TO) : 1;
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(FETCH_TO - 1);

    state_t           state_q, state_d;
    logic [TO_W-1:0]  fcnt_q;
    logic [5:0]       op_q, func_q;
    logic [4:0]       rd_q;
    logic [3:0]       alu_op_q;
    logic             wr_q;
    logic             fetch_err_q;
    logic [CNT_W-1:0] cnt_q;
    logic             trap_q;

    logic [3:0]       dec_alu_op;
    logic             dec_wr, dec_legal;
    logic             fetch_ack, fetch_to_hit;

    assign fetch_ack    = (state_q == ST_FETCH) && imem.imem_ack;
    // Last permitted wait cycle; an ack in that same cycle still wins.
    assign fetch_to_hit = (FETCH_TO != 0) && (fcnt_q == TO_LAST);

    rtype_alu_dec u_dec (
        .op     (op_q),
        .func   (func_q),
        .alu_op (dec_alu_op),
        .wr     (dec_wr),
        .legal  (dec_legal)
    );

    // Next-state selection.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:   if (run) state_d = ST_FETCH;
            ST_FETCH: begin
                if (imem.imem_ack)    state_d = ST_DECODE;
                else if (fetch_to_hit) state_d = ST_HALT;
            end
            ST_DECODE: state_d = ST_EXEC;
            ST_EXEC:   state_d = ST_WB;
            ST_WB: begin
                if (trap_q)   state_d = ST_HALT;
                else if (run) state_d = ST_FETCH;
                else          state_d = ST_IDLE;
            end
            ST_HALT:   state_d = ST_HALT;
            default:   state_d = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // Fetch wait counter, cleared whenever not waiting in FETCH.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                                  fcnt_q <= '0;
        else if ((state_q == ST_FETCH) && !imem.imem_ack) fcnt_q <= fcnt_q + TO_W'(1);
        else                                         fcnt_q <= '0;
    end

    // Capture instruction fields on the same edge the IR is loaded.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q   <= '0;
            func_q <= '0;
            rd_q   <= '0;
        end else if (fetch_ack) begin
            op_q   <= imem.instr[31:26];
            func_q <= imem.instr[5:0];
            rd_q   <= imem.instr[15:11];
        end
    end

    // Register decoder outputs in DECODE; held until the next DECODE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_op_q <= ALU_AND;
            wr_q     <= 1'b0;
        end else if (state_q == ST_DECODE) begin
            alu_op_q <= dec_alu_op;
            wr_q     <= dec_wr;
        end
    end

    // Sticky fetch error and retired-instruction counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_err_q <= 1'b0;
            cnt_q       <= '0;
        end else begin
            if ((state_q == ST_FETCH) && !imem.imem_ack && fetch_to_hit) fetch_err_q <= 1'b1;
            if ((state_q == ST_WB) && !trap_q) cnt_q <= cnt_q + CNT_W'(1);
        end
    end

`ifdef RTYPE_ILLEGAL_TRAP_EN
    logic illegal_q;

    // Flag illegal instructions at DECODE; trap_q steers WB into HALT.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            illegal_q <= 1'b0;
            trap_q    <= 1'b0;
        end else if (state_q == ST_DECODE) begin
            trap_q <= !dec_legal;
            if (!dec_legal) illegal_q <= 1'b1;
        end
    end

    assign illegal = illegal_q;
`else
    logic unused_legal;
    assign unused_legal = dec_legal;
    assign trap_q       = 1'b0;
    assign illegal      = 1'b0;
`endif

    // rs/rt/shamt are consumed by the datapath, not the sequencer.
    logic unused_instr;
    assign unused_instr = ^{imem.instr[25:16], imem.instr[10:6]};

    assign imem.imem_req = (state_q == ST_FETCH);
    assign ir_we         = fetch_ack;
    assign pc_we         = fetch_ack;
    assign ab_we         = (state_q == ST_DECODE);
    assign alu_res_we    = (state_q == ST_EXEC);
    assign rf_we         = (state_q == ST_WB) && wr_q;
    assign rf_waddr      = rd_q;
    assign alu_op        = alu_op_q;
    assign busy          = (state_q != ST_IDLE) && (state_q != ST_HALT);
    assign fetch_err     = fetch_err_q;
    assign retired_cnt   = cnt_q;

endmodule

// File: tb/tb_rtype_seq_ctrl.sv
// Randomized scoreboard bench for rtype_seq_ctrl. Stimulus pushes one
// expected record per fetched instruction; a monitor pops it when the DUT
// enters EXEC and checks EXEC, WB and the retired count that follows.
module tb_rtype_seq_ctrl;

    localparam int unsigned CNT_W    = 4;
    localparam int unsigned FETCH_TO = 15;

`ifdef RTYPE_ILLEGAL_TRAP_EN
    localparam bit TrapEn = 1'b1;
`else
    localparam bit TrapEn = 1'b0;
`endif

    typedef struct {
        logic [3:0] alu;
        logic       wr;
        logic [4:0] rd;
        int         cnt;
        logic       ill;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             run = 1'b0;
    logic             ir_we, pc_we, ab_we, alu_res_we, rf_we;
    logic [4:0]       rf_waddr;
    logic [3:0]       alu_op;
    logic             busy, fetch_err, illegal;
    logic [CNT_W-1:0] retired_cnt;

    rtype_seq_ctrl_if bus ();

    rtype_seq_ctrl #(
        .CNT_W    (CNT_W),
        .FETCH_TO (FETCH_TO)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .run         (run),
        .imem        (bus),
        .ir_we       (ir_we),
        .pc_we       (pc_we),
        .ab_we       (ab_we),
        .alu_res_we  (alu_res_we),
        .rf_we       (rf_we),
        .rf_waddr    (rf_waddr),
        .alu_op      (alu_op),
        .busy        (busy),
        .fetch_err   (fetch_err),
        .illegal     (illegal),
        .retired_cnt (retired_cnt)
    );

    always #5 clk = ~clk;

    // Reference table: func code and its ALU opcode.
    logic [5:0] fn_tab  [8] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2b, 6'h04};
    logic [3:0] alu_tab [8] = '{4'd4, 4'd5, 4'd0, 4'd1, 4'd2, 4'd3, 4'd6, 4'd7};

    exp_t sb[$];
    exp_t mon_e;
    int   n_vec = 0;
    int   n_err = 0;
    int   exp_cnt = 0;
    logic exp_ill = 1'b0;
    int   exp_rf = 0;
    int   act_rf = 0;
    int   last_wait = 0;
    int   en_sum;

    function automatic void chk(input string name, input logic [31:0] act,
                                input logic [31:0] want);
        n_vec++;
        if (act !== want) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, want, $time);
        end
    endfunction

    function automatic void bound_fail(input string name);
        n_vec++;
        n_err++;
        $display("FAIL %s: wait bound expired (t=%0t)", name, $time);
    endfunction

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    function automatic logic [31:0] mk(input logic [5:0] fn, input logic [4:0] rd);
        logic [4:0] rs = 5'($urandom);
        logic [4:0] rt = 5'($urandom);
        return {6'd0, rs, rt, rd, 5'd0, fn};
    endfunction

    function automatic logic [31:0] rand_legal();
        int unsigned k = $urandom_range(0, 8);
        logic [5:0] fn = (k == 8) ? 6'd0 : fn_tab[k];
        return mk(fn, 5'($urandom));
    endfunction

    // Issue one instruction: wait for the request, answer after lat cycles,
    // and queue the expected outcome.
    task automatic issue(input logic [31:0] w, input int lat);
        exp_t e;
        logic [5:0] op = w[31:26];
        logic [5:0] fn = w[5:0];
        logic       in_tab = 1'b0;
        logic       legal;
        logic       trap;
        int         k = 0;
        while (!bus.imem_req && k < 60) begin
            step();
            k++;
        end
        last_wait = k;
        if (!bus.imem_req) bound_fail("imem_req_wait");
        repeat (lat) step();
        bus.imem_ack = 1'b1;
        bus.instr    = w;
        #1;
        chk("ir_we_on_ack", ir_we, 1);
        chk("pc_we_on_ack", pc_we, 1);
        e.alu = 4'd0;
        for (int i = 0; i < 8; i++) begin
            if (op == 6'd0 && fn == fn_tab[i]) begin
                in_tab = 1'b1;
                e.alu  = alu_tab[i];
            end
        end
        legal   = (op == 6'd0) && (in_tab || fn == 6'd0);
        trap    = TrapEn && !legal;
        e.wr    = in_tab;
        e.rd    = w[15:11];
        if (!trap) exp_cnt = (exp_cnt + 1) % (1 << CNT_W);
        exp_ill = exp_ill | trap;
        e.cnt   = exp_cnt;
        e.ill   = exp_ill;
        sb.push_back(e);
        step();
        bus.imem_ack = 1'b0;
        bus.instr    = $urandom;
    endtask

    task automatic drain();
        int k = 0;
        while (sb.size() != 0 && k < 100) begin
            step();
            k++;
        end
        if (sb.size() != 0) bound_fail("scoreboard_drain");
        repeat (3) step();
    endtask

    task automatic do_reset();
        rst_n        = 1'b0;
        run          = 1'b0;
        bus.imem_ack = 1'b0;
        bus.instr    = '0;
        step();
        sb.delete();
        exp_cnt = 0;
        exp_ill = 1'b0;
        chk("rst_imem_req", bus.imem_req, 0);
        chk("rst_ir_we", ir_we, 0);
        chk("rst_pc_we", pc_we, 0);
        chk("rst_ab_we", ab_we, 0);
        chk("rst_alu_res_we", alu_res_we, 0);
        chk("rst_rf_we", rf_we, 0);
        chk("rst_rf_waddr", rf_waddr, 0);
        chk("rst_alu_op", alu_op, 0);
        chk("rst_busy", busy, 0);
        chk("rst_fetch_err", fetch_err, 0);
        chk("rst_illegal", illegal, 0);
        chk("rst_retired_cnt", retired_cnt, 0);
        rst_n = 1'b1;
        step();
    endtask

    // Monitor: pop on EXEC, then check WB and the count after WB.
    always begin : monitor
        @(negedge clk);
        if (rst_n && alu_res_we) begin
            if (sb.size() == 0) begin
                bound_fail("exec_without_fetch");
            end else begin
                mon_e = sb.pop_front();
                chk("alu_op_exec", alu_op, mon_e.alu);
                @(negedge clk);
                chk("rf_we_wb", rf_we, mon_e.wr);
                if (mon_e.wr) chk("rf_waddr_wb", rf_waddr, mon_e.rd);
                chk("alu_op_wb", alu_op, mon_e.alu);
                if (mon_e.wr) exp_rf++;
                @(negedge clk);
                chk("retired_cnt", retired_cnt, mon_e.cnt);
                chk("illegal", illegal, mon_e.ill);
            end
        end
    end

    // Enables are mutually exclusive and ir_we/pc_we coincide.
    always @(negedge clk) begin
        if (rst_n) begin
            en_sum = int'(ir_we) + int'(ab_we) + int'(alu_res_we) + int'(rf_we);
            chk("enables_exclusive", ((en_sum <= 1) && (ir_we == pc_we)) ? 1 : 0, 1);
            if (rf_we) act_rf++;
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int hi;
        logic [5:0] stream [8];
        stream = '{6'h22, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2b, 6'h04, 6'h20};

        // Single add after reset: ack one cycle after the request.
        do_reset();
        run = 1'b1;
        issue(32'h0085_1020, 1);
        chk("first_req_latency", last_wait, 1);
        run = 1'b0;
        drain();
        chk("add_retired", retired_cnt, 1);

        // Back-to-back stream of all eight operations.
        do_reset();
        base = act_rf;
        run  = 1'b1;
        for (int i = 0; i < 8; i++) begin
            issue(mk(stream[i], 5'($urandom_range(1, 31))), $urandom_range(1, 3));
            if (i == 7) run = 1'b0;
        end
        drain();
        chk("stream_rf_pulses", act_rf - base, 8);
        chk("stream_retired", retired_cnt, 8);

        // Counter wrap: 17 retirements on a 4-bit counter.
        do_reset();
        run = 1'b1;
        for (int i = 0; i < 17; i++) begin
            issue(rand_legal(), $urandom_range(1, 3));
            if (i == 16) run = 1'b0;
        end
        drain();
        chk("wrap_retired", retired_cnt, 1);
        chk("no_fetch_err", fetch_err, 0);

        // Fetch timeout: no ack for FETCH_TO cycles.
        do_reset();
        run = 1'b1;
        hi  = 0;
        step();
        while (bus.imem_req && hi < 40) begin
            hi++;
            step();
        end
        chk("timeout_req_cycles", hi, FETCH_TO);
        chk("timeout_fetch_err", fetch_err, 1);
        chk("timeout_busy", busy, 0);
        repeat (4) step();
        chk("halt_no_req", bus.imem_req, 0);

        // Ack on the last permitted cycle wins over the timeout.
        do_reset();
        run = 1'b1;
        issue(mk(6'h26, 5'd9), FETCH_TO - 1);
        run = 1'b0;
        drain();
        chk("late_ack_fetch_err", fetch_err, 0);

        // Drop run during EXEC: WB completes, then IDLE.
        do_reset();
        run = 1'b1;
        issue(mk(6'h20, 5'd7), 2);
        step();
        chk("in_exec", alu_res_we, 1);
        run = 1'b0;
        step();
        step();
        chk("stop_busy", busy, 0);
        chk("stop_req", bus.imem_req, 0);
        repeat (3) step();
        chk("stop_retired", retired_cnt, 1);

        // Reset during EXEC abandons the instruction with no write.
        base = act_rf;
        run  = 1'b1;
        issue(mk(6'h25, 5'd3), 1);
        step();
        rst_n = 1'b0;
        #1;
        chk("async_alu_res_we", alu_res_we, 0);
        chk("async_busy", busy, 0);
        chk("async_alu_op", alu_op, 0);
        chk("async_rf_waddr", rf_waddr, 0);
        do_reset();
        chk("abandon_no_rf_we", act_rf - base, 0);

        // NOP then OP=0x23: NOP counted; OP=0x23 is NOP or trap.
        run = 1'b1;
        issue(32'h0000_0000, 1);
        issue(32'h8C43_0000, 1);
        run = 1'b0;
        drain();
        chk("op23_retired", retired_cnt, TrapEn ? 1 : 2);
        chk("op23_illegal", illegal, TrapEn ? 1 : 0);
        run = 1'b1;
        step();
        step();
        chk("op23_halt", bus.imem_req, TrapEn ? 0 : 1);

        // OP=0 with a func outside the table.
        do_reset();
        base = act_rf;
        run  = 1'b1;
        issue(mk(6'h3f, 5'd12), 1);
        run = 1'b0;
        drain();
        chk("badfn_retired", retired_cnt, TrapEn ? 0 : 1);
        chk("badfn_illegal", illegal, TrapEn ? 1 : 0);
        chk("badfn_no_rf_we", act_rf - base, 0);
        run = 1'b1;
        step();
        step();
        chk("badfn_halt", bus.imem_req, TrapEn ? 0 : 1);

        do_reset();
        chk("total_rf_pulses", act_rf, exp_rf);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
